// File: rtl/egress_rr_arbiter.sv
// egress_rr_arbiter: drains the four PCIE output FIFOs (data_out4..data_out7)
// round-robin onto one registered egress stream, honouring destination
// back-pressure, with saturating per-channel forwarded-word counters that are
// read through the req/idx port pair.
// Optional build macro: EGRESS_STRICT_PRIO_EN (channel 0 strict priority,
// channels 1..3 round-robin among themselves).
module egress_rr_arbiter #(
  parameter int TAMANO_DATOS = 12,
  parameter int CNT_W        = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              empty_in,
  input  logic [TAMANO_DATOS-1:0] data_in0,
  input  logic [TAMANO_DATOS-1:0] data_in1,
  input  logic [TAMANO_DATOS-1:0] data_in2,
  input  logic [TAMANO_DATOS-1:0] data_in3,
  input  logic                    almost_full_dest,
  input  logic                    req,
  input  logic [2:0]              idx,
  output logic [3:0]              pop_out,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic                    valid_out,
  output logic [1:0]              grant_ch,
  output logic [CNT_W-1:0]        count_out,
  output logic                    count_valid
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_INIT   = 2'd1,
    S_IDLE   = 2'd2,
    S_ACTIVE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [3:0]              elig;
  logic                    gnt_any;
  logic [1:0]              gnt_ch;
  logic [1:0]              cand;

  // in-flight tracking: stage 1 = popped, FIFO data arriving this cycle
  logic                    s1_vld_q;
  logic [1:0]              s1_ch_q;
  logic [TAMANO_DATOS-1:0] sel_data;

  logic [TAMANO_DATOS-1:0] data_q;
  logic                    valid_q;
  logic [1:0]              grant_q;

  logic [CNT_W-1:0]        cnt_q [4];
  logic [CNT_W-1:0]        cnt_d [4];
  logic [CNT_W-1:0]        cnt_rd_q;
  logic                    cnt_vld_q;

  // Grant selection: first eligible channel after the pointer.
  always_comb begin
    elig    = '0;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    cand    = '0;
    ptr_d   = ptr_q;
    if (!almost_full_dest && (state_q == S_IDLE || state_q == S_ACTIVE)) begin
      elig = ~empty_in;
    end
`ifdef EGRESS_STRICT_PRIO_EN
    if (elig[0]) begin
      gnt_any = 1'b1;
      gnt_ch  = 2'd0;
    end else begin
      // channel 0 is excluded from the rotation; ptr only tracks 1..3
      for (int unsigned i = 1; i <= 4; i++) begin
        cand = ptr_q + 2'(i);
        if (!gnt_any && cand != 2'd0 && elig[cand]) begin
          gnt_any = 1'b1;
          gnt_ch  = cand;
        end
      end
      if (gnt_any) begin
        ptr_d = gnt_ch;
      end
    end
`else
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_ch  = cand;
      end
    end
    if (gnt_any) begin
      ptr_d = gnt_ch;
    end
`endif
  end

  assign pop_out = gnt_any ? (4'b0001 << gnt_ch) : 4'b0000;

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   state_d = S_IDLE;
      S_IDLE:   if (gnt_any) state_d = S_ACTIVE;
      S_ACTIVE: if (!gnt_any && !s1_vld_q) state_d = S_IDLE;
      default:  state_d = S_RESET;
    endcase
  end

  // FSM state and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FIFO read-data mux for the word popped last cycle.
  always_comb begin
    case (s1_ch_q)
      2'd0:    sel_data = data_in0;
      2'd1:    sel_data = data_in1;
      2'd2:    sel_data = data_in2;
      default: sel_data = data_in3;
    endcase
  end

  // Two-stage pop-to-egress pipeline; output word holds when no valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q <= 1'b0;
      s1_ch_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
    end else begin
      s1_vld_q <= gnt_any;
      s1_ch_q  <= gnt_ch;
      valid_q  <= s1_vld_q;
      if (s1_vld_q) begin
        data_q  <= sel_data;
        grant_q <= s1_ch_q;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant_ch  = grant_q;

  // Saturating increment of the counter for the word on the output.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (valid_q && cnt_q[grant_q] != '1) begin
      cnt_d[grant_q] = cnt_q[grant_q] + 1'b1;
    end
  end

  // Counter storage and registered read port (reads see pre-increment value).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      cnt_rd_q  <= '0;
      cnt_vld_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      cnt_vld_q <= req;
      cnt_rd_q  <= (req && !idx[2]) ? cnt_q[idx[1:0]] : '0;
    end
  end

  assign count_out   = cnt_rd_q;
  assign count_valid = cnt_vld_q;

endmodule
